mem_byte_master: RTL and testbench

MEM_BYTE_MASTER -- requirements
Module: mem_byte_master

---
 rtl/mem_byte_master.sv | 149 ++++++++++++++
 tb/tb_mem_byte_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_master.sv
// rtl/mem_byte_master.sv - core word/byte request master for an 8-bit memory bus
// Splits each word request into four big-endian byte beats; a byte request is one beat.
module mem_byte_master #(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_writedata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  beat;
    logic        we_r;
    logic        size_r;
    logic [15:0] addr_r;
    logic [31:0] wdata_r;
    logic        err_r;
    logic        accept;
    logic        misaligned;
    logic        last_beat;
    logic [7:0]  wbyte;

    assign accept     = req && (state != XFER);
    assign misaligned = (ALIGN_CHECK != 0) && size && (addr[1:0] != 2'b00);
    assign last_beat  = (beat == (size_r ? 2'd3 : 2'd0));

    // Big-endian lane select: beat 0 carries the most significant byte.
    always_comb begin
        wbyte = wdata_r[7:0];
        if (size_r) begin
            case (beat)
                2'd0:    wbyte = wdata_r[31:24];
                2'd1:    wbyte = wdata_r[23:16];
                2'd2:    wbyte = wdata_r[15:8];
                default: wbyte = wdata_r[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = misaligned ? DONE : XFER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = 16'h0000;
        mem_writedata = 8'h00;
        case (state)
            XFER: begin
                busy          = 1'b1;
                mem_read      = !we_r;
                mem_write     = we_r;
                mem_addr      = addr_r + {14'b0, beat};
                mem_writedata = we_r ? wbyte : 8'h00;
            end
            DONE: begin
                done = 1'b1;
                err  = err_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat    <= 2'd0;
            we_r    <= 1'b0;
            size_r  <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 32'h0;
            err_r   <= 1'b0;
        end else if (accept) begin
            beat    <= 2'd0;
            we_r    <= we;
            size_r  <= size;
            addr_r  <= addr;
            wdata_r <= wdata;
            err_r   <= misaligned;
        end else if (state == XFER) begin
            beat <= beat + 2'd1;
        end
    end

    // Read data lands in its lane at the edge that ends each read beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (state == XFER && !we_r) begin
            if (size_r) begin
                case (beat)
                    2'd0:    rdata[31:24] <= mem_data;
                    2'd1:    rdata[23:16] <= mem_data;
                    2'd2:    rdata[15:8]  <= mem_data;
                    default: rdata[7:0]   <= mem_data;
                endcase
            end else begin
                rdata <= {24'h0, mem_data};
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_master.sv
// tb/tb_mem_byte_master.sv - directed self-checking bench for mem_byte_master
module tb_mem_byte_master;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic        size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_data;

    logic [7:0]  mem [0:65535];
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;

    int n_checks;
    int n_errors;

    mem_byte_master #(.ALIGN_CHECK(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .size          (size),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rdata         (rdata),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_data      (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Presents a request for one edge (edge N); returns at the negedge of cycle N+1.
    task automatic issue(input logic w, input logic s, input logic [15:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        size  = s;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req   = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
    endfunction

    initial begin
        logic [31:0] wr_word;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req       = 1'b0;
        we        = 1'b0;
        size      = 1'b0;
        addr      = 16'h0;
        wdata     = 32'h0;
        load_en   = 1'b0;
        load_addr = 16'h0;
        load_data = 8'h0;
        @(negedge clk);

        check("reset_outputs", {busy, done, err, mem_read, mem_write}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_bus", {mem_addr, 8'h00, mem_writedata}, 32'h0);

        load(16'h0000, 8'h00); load(16'h0001, 8'h43); load(16'h0002, 8'h08); load(16'h0003, 8'h20);
        load(16'h0005, 8'h7F);
        for (int i = 0; i < 8; i++) load(16'h0104 + 16'(i), 8'h00);
        for (int i = 0; i < 4; i++) load(16'h0010 + 16'(i), 8'h00);
        load(16'h0020, 8'h00);
        load(16'hFFFC, 8'h11); load(16'hFFFD, 8'h22); load(16'hFFFE, 8'h33); load(16'hFFFF, 8'h44);
        reset = 1'b0;
        @(negedge clk);

        // Word read, big-endian assembly
        issue(1'b0, 1'b1, 16'h0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrd_addr%0d", k), {16'h0, mem_addr}, 32'(k));
            check($sformatf("wrd_ctl%0d", k), {busy, done, mem_read, mem_write}, 32'b1010);
            @(negedge clk);
        end
        check("wrd_done", {busy, done, err}, 32'b010);
        check("wrd_rdata", rdata, 32'h00430820);
        @(negedge clk);
        check("wrd_idle", {busy, done}, 32'b00);

        // Word write
        wr_word = 32'hA0030302;
        issue(1'b1, 1'b1, 16'h0104, wr_word);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wwr_addr%0d", k), {16'h0, mem_addr}, 32'h0104 + 32'(k));
            check($sformatf("wwr_data%0d", k), {24'h0, mem_writedata}, {24'h0, wr_word[8*(3-k) +: 8]});
            check($sformatf("wwr_ctl%0d", k), {mem_read, mem_write}, 32'b01);
            @(negedge clk);
        end
        check("wwr_done", {busy, done, err}, 32'b010);
        check("wwr_rdata_kept", rdata, 32'h00430820);
        check("wwr_mem", mem_word(16'h0104), 32'hA0030302);
        check("wwr_mem_after", {24'h0, mem[16'h0108]}, 32'h0);
        @(negedge clk);

        // Byte read, zero-extended
        issue(1'b0, 1'b0, 16'h0005, 32'h0);
        check("brd_beat", {15'h0, mem_read, mem_addr}, {15'h0, 1'b1, 16'h0005});
        @(negedge clk);
        check("brd_done", {busy, done, err, mem_read}, 32'b0100);
        check("brd_rdata", rdata, 32'h0000007F);
        @(negedge clk);

        // Byte write uses the low byte only
        issue(1'b1, 1'b0, 16'h0020, 32'h12345678);
        check("bwr_beat", {mem_write, mem_writedata}, {1'b1, 8'h78});
        @(negedge clk);
        check("bwr_done", {done, err}, 32'b10);
        check("bwr_mem", {24'h0, mem[16'h0020]}, 32'h78);
        check("bwr_rdata_kept", rdata, 32'h0000007F);
        @(negedge clk);

        // Misaligned word read: rejected without bus activity
        issue(1'b0, 1'b1, 16'h0002, 32'h0);
        check("mis_done", {busy, done, err, mem_read, mem_write}, 32'b01100);
        check("mis_rdata_kept", rdata, 32'h0000007F);
        @(negedge clk);
        check("mis_idle", {busy, done, err}, 32'b000);

        // Reset during beat 2 of a word write
        issue(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        check("rst_beat2_addr", {16'h0, mem_addr}, 32'h0012);
        reset = 1'b1;
        #1;
        check("rst_async_ctl", {busy, done, err, mem_read, mem_write}, 32'h0);
        check("rst_async_bus", {mem_addr, 8'h00, mem_writedata}, 32'h0);
        check("rst_async_rdata", rdata, 32'h0);
        @(negedge clk);
        check("rst_no_done", {busy, done}, 32'b00);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem", mem_word(16'h0010), 32'hDEAD0000);
        issue(1'b0, 1'b1, 16'h0010, 32'h0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("rst_next_busy", {busy, done}, 32'b10);
        @(negedge clk);
        check("rst_next_done", {busy, done, err}, 32'b010);
        check("rst_next_rdata", rdata, 32'hDEAD0000);
        @(negedge clk);

        // Back-to-back at the top of the address space, req held through done
        req   = 1'b1;
        we    = 1'b0;
        size  = 1'b1;
        addr  = 16'hFFFC;
        wdata = 32'h0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_addr%0d", k), {16'h0, mem_addr}, 32'hFFFC + 32'(k));
            @(negedge clk);
        end
        check("b2b_done", {busy, done, err}, 32'b010);
        check("b2b_rdata", rdata, 32'h11223344);
        @(negedge clk);
        req = 1'b0;
        check("b2b_restart", {15'h0, busy, mem_addr}, {15'h0, 1'b1, 16'hFFFC});
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("b2b_last_beat", {16'h0, mem_addr}, 32'hFFFF);
        @(negedge clk);
        check("b2b_done2", {busy, done, err}, 32'b010);
        check("b2b_rdata2", rdata, 32'h11223344);
        @(negedge clk);

        // Byte read at 0xFFFF
        issue(1'b0, 1'b0, 16'hFFFF, 32'h0);
        check("top_byte_addr", {16'h0, mem_addr}, 32'hFFFF);
        @(negedge clk);
        check("top_byte_rdata", rdata, 32'h00000044);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
